// File: rtl/t5_wbk_if.sv
// Writeback-stage bus bundle: execute request, load-return handshake, GPRF write port and per-hart load-pending flags.
interface t5_wbk_if #(
    parameter int XLEN = 32
);
    logic            xwre;
    logic [1:0]      xhart;
    logic [4:0]      xrda;
    logic [XLEN-1:0] xres;

    logic            lvld;
    logic            lrdy;
    logic [1:0]      lhart;
    logic [4:0]      lrda;
    logic [2:0]      lfun;
    logic [XLEN-1:0] ldat;

    logic            mwre;
    logic [1:0]      mhart;
    logic [4:0]      rd0a;
    logic [XLEN-1:0] rd0d;
    logic [3:0]      lpend;

    modport master (
        output xwre, xhart, xrda, xres,
        output lvld, lhart, lrda, lfun, ldat,
        input  lrdy, mwre, mhart, rd0a, rd0d, lpend
    );

    modport slave (
        input  xwre, xhart, xrda, xres,
        input  lvld, lhart, lrda, lfun, ldat,
        output lrdy, mwre, mhart, rd0a, rd0d, lpend
    );
endinterface

// File: rtl/t5_wbk.sv
// Writeback stage: execute results win the GPRF port, queued load returns drain in order otherwise.
// Optional feature macro T5_WBK_LEXT_EN: sign/zero-extend load data according to lfun.
module t5_wbk #(
    parameter int XLEN   = 32,
    parameter int LDEPTH = 4,
    parameter int LAW    = 2
) (
    input  logic     sclk,
    input  logic     srst_n,
    t5_wbk_if.slave  bus
);
    localparam int CW = LAW + 2;
    localparam logic [LAW:0] FULL = (LAW+1)'(LDEPTH);

    logic [LAW:0]    count_reg, count_next;
    logic [LAW-1:0]  wptr_reg, rptr_reg;
    logic [1:0]      fh_mem [LDEPTH];
    logic [4:0]      fa_mem [LDEPTH];
    logic [XLEN-1:0] fd_mem [LDEPTH];
`ifdef T5_WBK_LEXT_EN
    logic [2:0]      ff_mem [LDEPTH];
`else
    logic            unused_lfun;
    assign unused_lfun = ^bus.lfun;
`endif

    logic            mwre_reg, lsrc_reg;
    logic [1:0]      mhart_reg;
    logic [4:0]      rd0a_reg;
    logic [XLEN-1:0] rd0d_reg;
    logic [XLEN-1:0] head_dat;
    logic            lrdy_w, exe_w, push_w, pop_w;
    logic [3:0]      lpend_w;

    assign lrdy_w = (count_reg != FULL);
    assign exe_w  = bus.xwre && (bus.xrda != 5'd0);
    // Loads to x0 are accepted but never queued or counted.
    assign push_w = bus.lvld && lrdy_w && (bus.lrda != 5'd0);
    assign pop_w  = !exe_w && (count_reg != '0);

`ifdef T5_WBK_LEXT_EN
    function automatic logic [XLEN-1:0] lext(input logic [2:0] f, input logic [XLEN-1:0] d);
        case (f)
            3'b000:  lext = {{(XLEN-8){d[7]}}, d[7:0]};
            3'b001:  lext = {{(XLEN-16){d[15]}}, d[15:0]};
            3'b100:  lext = {{(XLEN-8){1'b0}}, d[7:0]};
            3'b101:  lext = {{(XLEN-16){1'b0}}, d[15:0]};
            default: lext = d;
        endcase
    endfunction
    assign head_dat = lext(ff_mem[rptr_reg], fd_mem[rptr_reg]);
`else
    assign head_dat = fd_mem[rptr_reg];
`endif

    always_comb begin
        count_next = count_reg;
        if (push_w && !pop_w)
            count_next = count_reg + 1'b1;
        else if (pop_w && !push_w)
            count_next = count_reg - 1'b1;
    end

    // Storage is not reset; validity is tracked by count/pointers alone.
    always_ff @(posedge sclk) begin
        if (push_w) begin
            fh_mem[wptr_reg] <= bus.lhart;
            fa_mem[wptr_reg] <= bus.lrda;
            fd_mem[wptr_reg] <= bus.ldat;
`ifdef T5_WBK_LEXT_EN
            ff_mem[wptr_reg] <= bus.lfun;
`endif
        end
    end

    always_ff @(posedge sclk or negedge srst_n) begin
        if (!srst_n) begin
            count_reg <= '0;
            wptr_reg  <= '0;
            rptr_reg  <= '0;
            mwre_reg  <= 1'b0;
            lsrc_reg  <= 1'b0;
            mhart_reg <= '0;
            rd0a_reg  <= '0;
            rd0d_reg  <= '0;
        end else begin
            count_reg <= count_next;
            if (push_w)
                wptr_reg <= wptr_reg + 1'b1;
            if (exe_w) begin
                mwre_reg  <= 1'b1;
                lsrc_reg  <= 1'b0;
                mhart_reg <= bus.xhart;
                rd0a_reg  <= bus.xrda;
                rd0d_reg  <= bus.xres;
            end else if (pop_w) begin
                mwre_reg  <= 1'b1;
                lsrc_reg  <= 1'b1;
                mhart_reg <= fh_mem[rptr_reg];
                rd0a_reg  <= fa_mem[rptr_reg];
                rd0d_reg  <= head_dat;
                rptr_reg  <= rptr_reg + 1'b1;
            end else begin
                mwre_reg  <= 1'b0;
                lsrc_reg  <= 1'b0;
            end
        end
    end

    // A hart's count drops on the edge after its load write is presented to the GPRF.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_pend
            logic [CW-1:0] cnt_reg;
            logic          inc_w, dec_w;
            assign inc_w = push_w && (bus.lhart == 2'(gi));
            assign dec_w = mwre_reg && lsrc_reg && (mhart_reg == 2'(gi));
            always_ff @(posedge sclk or negedge srst_n) begin
                if (!srst_n)
                    cnt_reg <= '0;
                else if (inc_w && !dec_w)
                    cnt_reg <= cnt_reg + 1'b1;
                else if (dec_w && !inc_w)
                    cnt_reg <= cnt_reg - 1'b1;
            end
            assign lpend_w[gi] = (cnt_reg != '0);
        end
    endgenerate

    assign bus.lrdy  = lrdy_w;
    assign bus.mwre  = mwre_reg;
    assign bus.mhart = mhart_reg;
    assign bus.rd0a  = rd0a_reg;
    assign bus.rd0d  = rd0d_reg;
    assign bus.lpend = lpend_w;
endmodule

// File: tb/tb_t5_wbk.sv
// Randomized bench for t5_wbk against a queue-based model of the writeback rules.
module tb_t5_wbk;
    localparam int LDEPTH = 4;

    logic sclk = 1'b0;
    logic srst_n = 1'b0;
    always #5 sclk = ~sclk;

    t5_wbk_if #(.XLEN(32)) bus ();
    t5_wbk #(.XLEN(32), .LDEPTH(LDEPTH), .LAW(2)) dut (.sclk(sclk), .srst_n(srst_n), .bus(bus));

    typedef struct {
        logic [1:0]  h;
        logic [4:0]  a;
        logic [2:0]  f;
        logic [31:0] d;
    } ld_t;

    ld_t         q[$];
    logic        m_wre, m_isld;
    logic [1:0]  m_hart;
    logic [4:0]  m_rda;
    logic [31:0] m_dat;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ext(input logic [2:0] f, input logic [31:0] d);
        logic [31:0] r;
        r = d;
`ifdef T5_WBK_LEXT_EN
        if (f == 3'b000) r = 32'($signed(d[7:0]));
        if (f == 3'b001) r = 32'($signed(d[15:0]));
        if (f == 3'b100) r = d & 32'h0000_00ff;
        if (f == 3'b101) r = d & 32'h0000_ffff;
`else
        if (f == 3'b111) r = d;
`endif
        return r;
    endfunction

    // A load is pending while it sits in the queue or is the write currently on the GPRF port.
    function automatic logic [3:0] exp_pend();
        logic [3:0] p;
        p = 4'b0;
        if (m_wre && m_isld) p[m_hart] = 1'b1;
        foreach (q[i]) p[q[i].h] = 1'b1;
        return p;
    endfunction

    task automatic model_reset();
        q.delete();
        m_wre = 1'b0; m_isld = 1'b0; m_hart = '0; m_rda = '0; m_dat = '0;
    endtask

    task automatic step(input bit xw, input logic [1:0] xh, input logic [4:0] xa, input logic [31:0] xr,
                        input bit lv, input logic [1:0] lh, input logic [4:0] la, input logic [2:0] lf,
                        input logic [31:0] ld, output bit acc);
        ld_t e;
        bus.xwre = xw; bus.xhart = xh; bus.xrda = xa; bus.xres = xr;
        bus.lvld = lv; bus.lhart = lh; bus.lrda = la; bus.lfun = lf; bus.ldat = ld;
        chk("lrdy", 64'(bus.lrdy), 64'(q.size() < LDEPTH));
        chk("lpend", 64'(bus.lpend), 64'(exp_pend()));
        acc = lv && (q.size() < LDEPTH);
        if (xw && xa != 5'd0) begin
            m_wre = 1'b1; m_isld = 1'b0; m_hart = xh; m_rda = xa; m_dat = xr;
        end else if (q.size() != 0) begin
            e = q.pop_front();
            m_wre = 1'b1; m_isld = 1'b1; m_hart = e.h; m_rda = e.a; m_dat = ext(e.f, e.d);
        end else begin
            m_wre = 1'b0; m_isld = 1'b0;
        end
        if (acc && la != 5'd0) begin
            e.h = lh; e.a = la; e.f = lf; e.d = ld;
            q.push_back(e);
        end
        @(posedge sclk);
        #1;
        chk("mwre", 64'(bus.mwre), 64'(m_wre));
        chk("mhart", 64'(bus.mhart), 64'(m_hart));
        chk("rd0a", 64'(bus.rd0a), 64'(m_rda));
        chk("rd0d", 64'(bus.rd0d), 64'(m_dat));
        if (m_wre)
            $display("wr %s hart=%0d rd=%0d data=%08h", m_isld ? "ld" : "ex", m_hart, m_rda, m_dat);
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, a);
    endtask

    initial begin
        bit a;
        int nxt;
        bus.xwre = 0; bus.xhart = 0; bus.xrda = 0; bus.xres = 0;
        bus.lvld = 0; bus.lhart = 0; bus.lrda = 0; bus.lfun = 0; bus.ldat = 0;
        model_reset();
        #12;
        chk("rst_mwre", 64'(bus.mwre), 64'(0));
        chk("rst_lrdy", 64'(bus.lrdy), 64'(1));
        chk("rst_lpend", 64'(bus.lpend), 64'(0));
        chk("rst_rd0d", 64'(bus.rd0d), 64'(0));
        srst_n = 1'b1;
        @(posedge sclk); #1;

        // Execute write, one-cycle latency.
        step(1, 2, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, a);
        chk("t1_data", 64'(bus.rd0d), 64'h0DEADBEEF);
        idle(1);
        chk("t1_off", 64'(bus.mwre), 64'(0));

        // Single load: pending next cycle, written two cycles later, cleared after.
        step(0, 0, 0, 0, 1, 1, 7, 3'b010, 32'h12345678, a);
        chk("t2_pend1", 64'(bus.lpend), 64'(4'b0010));
        idle(1);
        chk("t2_wr", 64'({bus.mwre, bus.rd0a, bus.rd0d}), {1'b1, 5'd7, 32'h12345678});
        idle(1);
        chk("t2_pend0", 64'(bus.lpend), 64'(0));

        // Execute stream holds off five back-to-back loads; only four fit.
        nxt = 0;
        for (int c = 0; c < 16; c++) begin
            step(c < 8, 0, 3, 32'(c), nxt < 5, 2'(nxt), 5'(10 + nxt), 3'b010, 32'hA000 + 32'(nxt), a);
            if (a) nxt++;
        end
        chk("t3_all", 64'(nxt), 64'(5));

        // x0 execute does not block the pop; x0 load leaves nothing behind.
        step(0, 0, 0, 0, 1, 3, 9, 3'b010, 32'h55, a);
        step(1, 1, 0, 32'h77, 0, 0, 0, 0, 0, a);
        chk("t4_ld", 64'({bus.mwre, bus.rd0a}), {1'b1, 5'd9});
        idle(2);
        step(0, 0, 0, 0, 1, 2, 0, 3'b010, 32'h99, a);
        chk("t4_x0", 64'({bus.mwre, bus.lpend}), 64'(0));

        // Load extension cases.
        step(0, 0, 0, 0, 1, 0, 4, 3'b000, 32'h00000080, a); idle(2);
        step(0, 0, 0, 0, 1, 0, 4, 3'b100, 32'h00000080, a); idle(2);
        step(0, 0, 0, 0, 1, 0, 4, 3'b101, 32'h0000F000, a); idle(2);
        step(0, 0, 0, 0, 1, 0, 4, 3'b001, 32'h00008001, a); idle(2);

        // Randomized traffic alternating between execute-heavy and load-heavy phases.
        for (int i = 0; i < 1600; i++) begin
            int xp;
            xp = ((i / 100) % 2 == 0) ? 90 : 30;
            step($urandom_range(99) < xp, 2'($urandom), ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom),
                 $urandom, $urandom_range(99) < 60, 2'($urandom),
                 ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom), 3'($urandom), $urandom, a);
        end

        // Asynchronous reset mid-cycle with loads queued.
        for (int c = 0; c < 3; c++)
            step(1, 1, 2, 32'(c), 1, 2'(c), 5'(20 + c), 3'b010, 32'(c), a);
        #2;
        srst_n = 1'b0;
        #1;
        chk("t6_mwre", 64'(bus.mwre), 64'(0));
        chk("t6_lpend", 64'(bus.lpend), 64'(0));
        chk("t6_lrdy", 64'(bus.lrdy), 64'(1));
        model_reset();
        bus.xwre = 0; bus.lvld = 0;
        @(negedge sclk);
        srst_n = 1'b1;
        @(posedge sclk); #1;
        idle(4);
        chk("t6_quiet", 64'(bus.mwre), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
